// File: rtl/fifo_uart_tx.sv
// Drains the AD sample FIFO as UART 8N1 (8E1 with UART_TX_PARITY_EN), LSB first.
// Flags every completed 0x0D,0x0A frame terminator with frame_done / frame_cnt.
module fifo_uart_tx #(
    parameter int BAUD_DIV    = 434,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [7:0]             fifo_q,
    output logic                   fifo_rdreq,
    output logic                   uart_txd,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE, RD, LAT, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t      state, state_n;
    logic [15:0] baud_cnt, baud_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [7:0]  shift_reg;
    logic [7:0]  prev_byte;
    logic        txd_n;
    logic        baud_last;
    logic        stop_end;
    logic        is_frame;

    assign baud_last  = (baud_cnt == 16'(BAUD_DIV - 1));
    assign stop_end   = (state == STOP) && baud_last;
    assign is_frame   = stop_end && (shift_reg == 8'h0A) && (prev_byte == 8'h0D);
    assign fifo_rdreq = (state == RD);
    assign busy       = (state != IDLE);

    always_comb begin
        state_n = state;
        baud_n  = baud_cnt + 16'd1;
        bit_n   = bit_cnt;
        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (enable && !fifo_empty) state_n = RD;
            end
            RD: begin
                baud_n  = '0;
                state_n = LAT;
            end
            LAT: begin
                baud_n  = '0;
                state_n = START;
            end
            START: begin
                if (baud_last) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        bit_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_last) begin
                    baud_n  = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                baud_n  = '0;
                bit_n   = '0;
                state_n = IDLE;
            end
        endcase

        // Line level follows the state being entered so uart_txd stays a flop.
        txd_n = 1'b1;
        case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = shift_reg[bit_n];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_n = ^shift_reg;
`endif
            default: txd_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            prev_byte  <= '0;
            uart_txd   <= 1'b1;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            uart_txd   <= txd_n;
            frame_done <= is_frame;
            if (state == LAT) shift_reg <= fifo_q;
            if (stop_end) prev_byte <= shift_reg;
            if (is_frame) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model plus a line-level reference built
// from byte lists, directed tables, reset/enable corners and random bursts.
module tb_fifo_uart_tx;

    localparam int B  = 4;
    localparam int CW = 3;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          fifo_empty;
    logic [7:0]    fifo_q;
    logic          fifo_rdreq;
    logic          uart_txd;
    logic          busy;
    logic          frame_done;
    logic [CW-1:0] frame_cnt;

    fifo_uart_tx #(.BAUD_DIV(B), .FRAME_CNT_W(CW)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .fifo_empty(fifo_empty),
        .fifo_q(fifo_q),
        .fifo_rdreq(fifo_rdreq),
        .uart_txd(uart_txd),
        .busy(busy),
        .frame_done(frame_done),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Normal-mode FIFO: data appears the cycle after rdreq.
    logic [7:0] mem [4096];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rdreq) begin
            fifo_q <= mem[rd_ptr % 4096];
            rd_ptr <= rd_ptr + 1;
        end
    end

    typedef struct packed {
        logic          txd;
        logic          busy;
        logic          rdreq;
        logic          done;
        logic [CW-1:0] cnt;
    } obs_t;

    typedef struct {
        logic [47:0] bytes;
        int          n;
        int          frames;
    } vec_t;

    obs_t       exp_q[$];
    logic [7:0] model_q[$];
    logic [7:0] prev_sent;
    logic [CW-1:0] cnt_m;
    int n_cmp = 0;
    int n_fail = 0;
    int obs_frames;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 4096] = b;
        wr_ptr = wr_ptr + 1;
        model_q.push_back(b);
    endtask

    function automatic void add(input logic t, input logic bz, input logic rq, input logic d);
        obs_t o;
        o.txd   = t;
        o.busy  = bz;
        o.rdreq = rq;
        o.done  = d;
        o.cnt   = cnt_m;
        exp_q.push_back(o);
    endfunction

    // Each byte: idle, read, latch, then NB line bits of B clocks each.
    // A byte starts only if enable was still high at the end of its idle cycle.
    function automatic void build(input int drop, input int tail);
        logic [7:0] b;
        logic       pend;
        logic       lvl;
        exp_q.delete();
        pend = 1'b0;
        while (model_q.size() > 0 && (drop < 0 || exp_q.size() < drop)) begin
            b = model_q.pop_front();
            if (pend) cnt_m = cnt_m + 1'b1;
            add(1'b1, 1'b0, 1'b0, pend);
            add(1'b1, 1'b1, 1'b1, 1'b0);
            add(1'b1, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < NB; k++) begin
                if (k == 0) lvl = 1'b0;
                else if (k <= 8) lvl = b[k-1];
                else if (k == 9 && NB == 11) lvl = ^b;
                else lvl = 1'b1;
                for (int j = 0; j < B; j++) add(lvl, 1'b1, 1'b0, 1'b0);
            end
            pend = (b == 8'h0A) && (prev_sent == 8'h0D);
            prev_sent = b;
        end
        if (pend) cnt_m = cnt_m + 1'b1;
        add(1'b1, 1'b0, 1'b0, pend);
        for (int i = 0; i < tail; i++) add(1'b1, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic run(input int drop, input int tail);
        obs_t o;
        build(drop, tail);
        obs_frames = 0;
        enable = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            o = {uart_txd, busy, fifo_rdreq, frame_done, frame_cnt};
            chk("line", 32'(o), 32'(exp_q[i]));
            if (fifo_rdreq) chk("underflow", 32'(fifo_empty), 32'd0);
            if (frame_done) obs_frames++;
            if (i == drop) enable = 1'b0;
            step();
        end
    endtask

    initial begin
        logic [7:0] s;
        int n;
        int pt;
        tbl[0] = '{48'h55, 1, 0};
        tbl[1] = '{48'h0A_0D_0A_41_0D, 5, 1};
        tbl[2] = '{48'h0A, 1, 0};
        tbl[3] = '{48'h0A_0D_0D, 3, 1};
        tbl[4] = '{48'h0D, 1, 0};
        tbl[5] = '{48'h0A, 1, 1};
        tbl[6] = '{48'h00_FF, 2, 0};

        prev_sent = 8'h00;
        cnt_m = '0;
        reset_n = 1'b0;
        enable = 1'b0;
        repeat (3) step();
        chk("rst_txd", 32'(uart_txd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rdreq", 32'(fifo_rdreq), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_cnt", 32'(frame_cnt), 32'd0);
        reset_n = 1'b1;
        step();

        foreach (tbl[v]) begin
            for (int k = 0; k < tbl[v].n; k++) push(tbl[v].bytes[8*k +: 8]);
            run(-1, 5);
            chk("tbl_frames", 32'(obs_frames), 32'(tbl[v].frames));
        end

        // Full scan frame: 32 samples, marker, CR, LF.
        for (int k = 0; k < 32; k++) begin
            s = 8'($urandom);
            if (s == 8'h0A) s = 8'h0B;
            push(s);
        end
        push(8'hCC);
        push(8'h0D);
        push(8'h0A);
        run(-1, 5);
        chk("scan_frames", 32'(obs_frames), 32'd1);

        // Enable dropped mid-byte: only the first byte goes out.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        run(10, 20);
        chk("fifo_left", 32'(wr_ptr - rd_ptr), 32'd3);
        run(-1, 5);

        // Long idle with an empty FIFO, then a single byte.
        run(-1, 1000);
        push(8'hA3);
        run(-1, 5);

        // Asynchronous reset in DATA bit 3 and in START.
        for (int r = 0; r < 2; r++) begin
            pt = (r == 0) ? 20 : 4;
            push(8'h0F);
            enable = 1'b1;
            repeat (pt) step();
            chk("pre_rst_txd", 32'(uart_txd), (r == 0) ? 32'd1 : 32'd0);
            reset_n = 1'b0;
            #1;
            chk("arst_txd", 32'(uart_txd), 32'd1);
            chk("arst_busy", 32'(busy), 32'd0);
            chk("arst_cnt", 32'(frame_cnt), 32'd0);
            step();
            reset_n = 1'b1;
            void'(model_q.pop_front());
            prev_sent = 8'h00;
            cnt_m = '0;
            step();
            push(8'hA3);
            push(8'h0D);
            push(8'h0A);
            run(-1, 5);
            chk("post_rst_frames", 32'(obs_frames), 32'd1);
        end

        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 10);
            for (int k = 0; k < n; k++) begin
                case ($urandom_range(0, 2))
                    0: push(8'h0D);
                    1: push(8'h0A);
                    default: push(8'($urandom));
                endcase
            end
            run(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 300)), 6);
        end
        run(-1, 5);
        chk("drained", 32'(wr_ptr - rd_ptr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
